// File: rtl/gshare_pht_btb_pkg.sv
// rtl/gshare_pht_btb_pkg.sv - counter encodings and PC slice helpers for the gshare predictor
package gshare_pht_btb_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  localparam ctr_t PHT_RESET = WNT;
  localparam int   MAX_XLEN  = 64;

  // Callers cast the wide results down to their own index/tag widths.
  function automatic logic [MAX_XLEN-1:0] pc_index(input logic [MAX_XLEN-1:0] pc,
                                                    input int hist_width);
    return (pc >> 2) & ((64'd1 << hist_width) - 64'd1);
  endfunction

  function automatic logic [MAX_XLEN-1:0] pc_tag(input logic [MAX_XLEN-1:0] pc,
                                                  input int hist_width);
    return pc >> (hist_width + 2);
  endfunction

endpackage

// File: rtl/gshare_pht_btb_sat_counter2.sv
// rtl/gshare_pht_btb_sat_counter2.sv - 2-bit saturating increment/decrement
module sat_counter2
  import gshare_pht_btb_pkg::*;
(
  input  ctr_t ctr,
  input  logic inc,
  output ctr_t next
);

  always_comb begin
    next = ctr;
    if (inc) begin
      if (ctr != ST) next = ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != SNT) next = ctr_t'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/gshare_pht_btb.sv
// rtl/gshare_pht_btb.sv - gshare PHT plus direct-mapped BTB next-PC predictor with EX-stage training
module gshare_pht_btb
  import gshare_pht_btb_pkg::*;
#(
  parameter int HIST_WIDTH = 5,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       if_pc,
  input  logic [HIST_WIDTH-1:0] bhsr_in,
  output logic                  pred_taken,
  output logic [XLEN-1:0]       pred_target,
  output logic [HIST_WIDTH-1:0] pred_idx,
  input  logic                  upd_valid,
  input  logic                  upd_is_cond,
  input  logic [XLEN-1:0]       upd_pc,
  input  logic [HIST_WIDTH-1:0] upd_idx,
  input  logic                  upd_taken,
  input  logic [XLEN-1:0]       upd_target,
  input  logic                  upd_pred_taken,
  input  logic [XLEN-1:0]       upd_pred_target,
  output logic                  mispredict,
  output logic                  bhsr_update_en,
  output logic                  bhsr_taken,
  output logic [31:0]           br_count,
  output logic [31:0]           mp_count
);

  localparam int N     = 1 << HIST_WIDTH;
  localparam int TAG_W = XLEN - HIST_WIDTH - 2;

  ctr_t             pht        [N];
  logic             btb_valid  [N];
  logic [TAG_W-1:0] btb_tag    [N];
  logic [XLEN-1:0]  btb_target [N];

  logic [HIST_WIDTH-1:0] if_btb_idx, upd_btb_idx;
  logic [TAG_W-1:0]      if_tag, upd_tag;
  ctr_t                  pht_rd, pht_next;
  logic                  btb_hit;
  logic [XLEN-1:0]       actual_next;
  logic                  pht_we, btb_we;

  // Mispredict is judged on next-PC alone, so the fetch-time direction bit is not needed.
  logic unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken;

  assign if_btb_idx  = HIST_WIDTH'(pc_index(MAX_XLEN'(if_pc), HIST_WIDTH));
  assign if_tag      = TAG_W'(pc_tag(MAX_XLEN'(if_pc), HIST_WIDTH));
  assign upd_btb_idx = HIST_WIDTH'(pc_index(MAX_XLEN'(upd_pc), HIST_WIDTH));
  assign upd_tag     = TAG_W'(pc_tag(MAX_XLEN'(upd_pc), HIST_WIDTH));

  assign pred_idx    = if_btb_idx ^ bhsr_in;
  assign pht_rd      = pht[pred_idx];
  assign btb_hit     = btb_valid[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);
  assign pred_taken  = btb_hit && pht_rd[1];
  assign pred_target = pred_taken ? btb_target[if_btb_idx] : if_pc + XLEN'(4);

  assign actual_next    = upd_taken ? upd_target : upd_pc + XLEN'(4);
  assign mispredict     = upd_valid && (actual_next != upd_pred_target);
  assign bhsr_update_en = upd_valid && upd_is_cond;
  assign bhsr_taken     = upd_taken;

  assign pht_we = upd_valid && upd_is_cond;
  assign btb_we = upd_valid && upd_taken;

  sat_counter2 u_sat (
    .ctr  (pht[upd_idx]),
    .inc  (upd_taken),
    .next (pht_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        pht[i]       <= PHT_RESET;
        btb_valid[i] <= 1'b0;
      end
      br_count <= 32'd0;
      mp_count <= 32'd0;
    end else begin
      if (pht_we) pht[upd_idx] <= pht_next;
      if (btb_we) begin
        btb_valid[upd_btb_idx]  <= 1'b1;
        btb_tag[upd_btb_idx]    <= upd_tag;
        btb_target[upd_btb_idx] <= upd_target;
      end
      if (bhsr_update_en) br_count <= br_count + 32'd1;
      if (mispredict)     mp_count <= mp_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_gshare_pht_btb.sv
// tb/tb_gshare_pht_btb.sv - scoreboard bench for gshare_pht_btb
module tb_gshare_pht_btb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic [4:0]  bhsr_in;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [4:0]  pred_idx;
  logic        upd_valid, upd_is_cond, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic [4:0]  upd_idx;
  logic        mispredict, bhsr_update_en, bhsr_taken;
  logic [31:0] br_count, mp_count;

  gshare_pht_btb #(.HIST_WIDTH(5), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .bhsr_in(bhsr_in),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_is_cond(upd_is_cond), .upd_pc(upd_pc),
    .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .bhsr_update_en(bhsr_update_en),
    .bhsr_taken(bhsr_taken), .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [31:0] dut_sig(input int sel);
    case (sel)
      0:       return {31'd0, pred_taken};
      1:       return pred_target;
      2:       return {27'd0, pred_idx};
      3:       return {31'd0, mispredict};
      4:       return {31'd0, bhsr_update_en};
      5:       return {31'd0, bhsr_taken};
      6:       return br_count;
      default: return mp_count;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_e   = q.pop_front();
      mon_act = dut_sig(mon_e.sel);
      checks++;
      if (mon_act !== mon_e.exp) begin
        failures++;
        $display("FAIL %s actual=%0h expected=%0h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic push(input string n, input int sel, input logic [31:0] v);
    q.push_back('{n, sel, v});
  endtask

  task automatic lookup(input string n, input logic [31:0] pc, input logic [4:0] h,
                        input logic tk, input logic [31:0] tgt);
    if_pc   = pc;
    bhsr_in = h;
    push({n, "_taken"}, 0, {31'd0, tk});
    push({n, "_target"}, 1, tgt);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic counts(input string n, input logic [31:0] br, input logic [31:0] mp);
    push({n, "_br"}, 6, br);
    push({n, "_mp"}, 7, mp);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input string n, input logic cond, input logic [31:0] pc,
                     input logic [4:0] idx, input logic tk, input logic [31:0] tgt,
                     input logic [31:0] ptgt, input logic chk, input logic exp_mp);
    upd_valid       = 1'b1;
    upd_is_cond     = cond;
    upd_pc          = pc;
    upd_idx         = idx;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_target = ptgt;
    if (chk) begin
      push({n, "_mispredict"}, 3, {31'd0, exp_mp});
      push({n, "_update_en"}, 4, {31'd0, cond});
      push({n, "_hist_taken"}, 5, {31'd0, tk});
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; if_pc = 32'h0; bhsr_in = 5'd0;
    upd_valid = 1'b0; upd_is_cond = 1'b0; upd_pc = 32'h0; upd_idx = 5'd0;
    upd_taken = 1'b0; upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    push("reset_idx", 2, 32'd0);
    lookup("reset", 32'h100, 5'd0, 1'b0, 32'h104);
    counts("reset_cnt", 32'd0, 32'd0);

    // first taken conditional trains PHT[0] to WT and fills BTB[0]
    upd("t2", 1'b1, 32'h100, 5'd0, 1'b1, 32'h80, 32'h104, 1'b1, 1'b1);
    lookup("t2_pred", 32'h100, 5'd0, 1'b1, 32'h80);
    counts("t2_cnt", 32'd1, 32'd1);

    // saturation high at idx 3, then decrement
    for (int i = 0; i < 4; i++)
      upd("t3_inc", 1'b1, 32'h10C, 5'd3, 1'b1, 32'h200, 32'h200, 1'b0, 1'b0);
    lookup("t3_sat", 32'h10C, 5'd0, 1'b1, 32'h200);
    upd("t3_dec1", 1'b1, 32'h10C, 5'd3, 1'b0, 32'h200, 32'h110, 1'b1, 1'b0);
    lookup("t3_after1", 32'h10C, 5'd0, 1'b1, 32'h200);
    upd("t3_dec2", 1'b1, 32'h10C, 5'd3, 1'b0, 32'h200, 32'h110, 1'b0, 1'b0);
    lookup("t3_after2", 32'h10C, 5'd0, 1'b0, 32'h110);

    // saturation low at idx 7
    for (int i = 0; i < 2; i++)
      upd("t3_nt", 1'b1, 32'h11C, 5'd7, 1'b0, 32'h300, 32'h120, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      upd("t3_t", 1'b1, 32'h11C, 5'd7, 1'b1, 32'h300, 32'h300, 1'b0, 1'b0);
    lookup("t3_low", 32'h11C, 5'd0, 1'b1, 32'h300);
    counts("t3_cnt", 32'd11, 32'd1);

    // XOR indexing
    push("t4_xor_idx", 2, 32'd0);
    lookup("t4_xor", 32'h10C, 5'b00011, 1'b1, 32'h200);
    push("t4_idx1", 2, 32'd1);
    lookup("t4_pre", 32'h100, 5'd1, 1'b0, 32'h104);
    upd("t4_upd0", 1'b1, 32'h100, 5'd0, 1'b0, 32'h80, 32'h104, 1'b1, 1'b0);
    lookup("t4_post", 32'h100, 5'd1, 1'b0, 32'h104);
    lookup("t4_idx0", 32'h100, 5'd0, 1'b0, 32'h104);

    // same-cycle read and write of PHT[0]: old value seen, new next cycle
    if_pc = 32'h100; bhsr_in = 5'd0;
    push("t5_same_taken", 0, 32'd0);
    push("t5_same_target", 1, 32'h104);
    upd("t5_upd", 1'b1, 32'h100, 5'd0, 1'b1, 32'h80, 32'h80, 1'b1, 1'b0);
    lookup("t5_next", 32'h100, 5'd0, 1'b1, 32'h80);
    counts("t5_cnt", 32'd13, 32'd1);

    // reset wins over a same-cycle mispredicting update
    reset = 1'b1;
    upd("t5_rst", 1'b1, 32'h100, 5'd0, 1'b1, 32'h80, 32'h104, 1'b1, 1'b1);
    reset = 1'b0;
    counts("t5_rst_cnt", 32'd0, 32'd0);
    lookup("t5_rst_pred", 32'h100, 5'd0, 1'b0, 32'h104);
    upd("t5_retrain", 1'b1, 32'h100, 5'd0, 1'b1, 32'h80, 32'h80, 1'b0, 1'b0);
    lookup("t5_retrain_pred", 32'h100, 5'd0, 1'b1, 32'h80);

    // BTB alias via JAL, and JAL leaves PHT and br_count alone
    upd("t6_jal_alias", 1'b0, 32'h180, 5'd0, 1'b1, 32'h400, 32'h184, 1'b1, 1'b1);
    lookup("t6_miss", 32'h100, 5'd0, 1'b0, 32'h104);
    lookup("t6_hit", 32'h180, 5'd0, 1'b1, 32'h400);
    upd("t6_jal5", 1'b0, 32'h194, 5'd5, 1'b1, 32'h500, 32'h500, 1'b1, 1'b0);
    lookup("t6_pht5", 32'h194, 5'd0, 1'b0, 32'h198);
    counts("t6_cnt", 32'd1, 32'd1);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gshare_pht_btb.md
Name: gshare_pht_btb

Overview:
- Read-side and update-side consumer of the global branch history register.
- In IF it XORs the current history value with PC bits to index a pattern history table (PHT) of 2-bit saturating counters, and pairs the result with a direct-mapped BTB to produce the next-PC prediction.
- In EX it receives the resolved outcome, trains the PHT and BTB, flags mispredicts, and emits the update_en/taken pair that drives the history register.

Parameters:
- HIST_WIDTH, 5: history bits; PHT and BTB each have 2^HIST_WIDTH entries.
- XLEN, 32: PC/target width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_pc  in  XLEN  fetch PC
- bhsr_in  in  HIST_WIDTH  current global history value
- pred_taken  out  1  predicted taken
- pred_target  out  XLEN  predicted next PC
- pred_idx  out  HIST_WIDTH  PHT index used; carried down the pipeline
- upd_valid  in  1  EX-stage resolution valid this cycle
- upd_is_cond  in  1  conditional branch (0 = JAL/JALR)
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_idx  in  HIST_WIDTH  pred_idx captured at fetch
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual taken target
- upd_pred_taken  in  1  prediction made at fetch
- upd_pred_target  in  XLEN  predicted next PC made at fetch
- mispredict  out  1  resolved next PC differs from predicted next PC
- bhsr_update_en  out  1  drives history register update_en
- bhsr_taken  out  1  drives history register taken
- br_count  out  32  conditional branches resolved
- mp_count  out  32  mispredicts (all control-flow types)

Behaviour:
Storage and reset
- PHT: 2^HIST_WIDTH x 2-bit counters.
- BTB: 2^HIST_WIDTH entries of {valid, tag = pc[XLEN-1:HIST_WIDTH+2], target}, indexed by pc[HIST_WIDTH+1:2].
- Synchronous reset: all PHT counters <= 2'b01 (weakly not-taken); all BTB valid <= 0; br_count <= 0; mp_count <= 0.
- Reset has priority over any update in the same cycle. Reset asserted mid-stream discards that cycle's update.

Prediction (combinational, zero latency)
- pred_idx = if_pc[HIST_WIDTH+1:2] ^ bhsr_in.
- btb_hit = valid && (tag == if_pc[XLEN-1:HIST_WIDTH+2]).
- pred_taken = btb_hit && PHT[pred_idx][1].
- pred_target = pred_taken ? BTB.target : if_pc + 4.
- While reset is asserted, the outputs reflect the pre-reset tables (prediction reads are combinational). From the first cycle after reset deassertion, pred_taken = 0 and pred_target = if_pc + 4.

Resolution (combinational outputs)
- actual_next = upd_taken ? upd_target : upd_pc + 4.
- mispredict = upd_valid && (actual_next != upd_pred_target).
- bhsr_update_en = upd_valid && upd_is_cond.
- bhsr_taken = upd_taken.

Update (written at posedge, visible the next cycle)
- PHT update, only when upd_valid && upd_is_cond && !reset:
  - PHT[upd_idx] increments if taken, decrements otherwise.
  - Saturates at 2'b11 and 2'b00; no wrap.
- BTB update, when upd_valid && upd_taken && !reset:
  - Writes valid = 1, the tag, and upd_target at upd_pc's index.
  - Overwrites any aliasing entry.
  - Not-taken resolutions never invalidate an entry.
- Counters:
  - br_count += 1 when bhsr_update_en.
  - mp_count += 1 when mispredict.
  - Both wrap modulo 2^32.

Simultaneous events and indexing
- Same-cycle read and write of the same entry: the read returns the pre-write value (no bypass).
- PHT is indexed with upd_idx, never recomputed from upd_pc. Training therefore uses the history that existed at fetch, independent of later updates to the history register.

Decomposition:
- Shared package:
  - Counter encodings: SNT = 0, WNT = 1, WT = 2, ST = 3.
  - PHT reset value WNT.
  - PC-to-index and PC-to-tag slice helpers, parameterised by HIST_WIDTH.
- One natural sub-module, sat_counter2: the 2-bit saturating increment/decrement function, used by the PHT update path.
- BTB and PHT stay inline in gshare_pht_btb.

Test Plan:
1. Reset, then if_pc = 0x100, bhsr_in = 0 -> pred_taken = 0, pred_target = 0x104, pred_idx = 0, br_count = 0.
2. Resolve a conditional branch at upd_pc = 0x100, upd_idx = 0, taken, target 0x80, upd_pred_target = 0x104:
   - mispredict = 1, bhsr_update_en = 1, bhsr_taken = 1.
   - Next cycle: if_pc = 0x100, bhsr_in = 0 -> pred_taken = 1 (PHT[0] = 2), pred_target = 0x80.
3. Saturation: four taken updates at idx 3 -> counter 3; one not-taken -> 2 (prediction still taken). From 0, not-taken -> stays 0.
4. XOR indexing: bhsr_in = 5'b00011, if_pc = 0x10C -> pred_idx = 3 ^ 3 = 0. Update at idx 0 must not change the prediction at if_pc = 0x100, bhsr_in = 1 (idx 1).
5. Simultaneous: an update and a lookup of the same entry in one cycle -> the lookup shows the old counter; the new value appears the next cycle. Reset asserted together with an update -> counter = 1, mp_count = 0.
6. BTB alias: taken at 0x100, then taken at 0x100 + 4·2^HIST_WIDTH (0x180 for HIST_WIDTH = 5) -> lookup at 0x100 misses; pred_target = 0x104. A JAL update changes neither the PHT nor br_count.
